// File: rtl/fpusqr_alt_wb_queue.sv
// Result buffer between the FP sqrt/divide unit and the register-file alternate write port.
// Entries drain in FIFO order whenever main writeback leaves the port free.
module fpusqr_alt_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 84,
  parameter int II_W   = 10,
  parameter int REG_W  = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       except,
  input  logic [3:0]                 in_en,
  input  logic [II_W-1:0]            in_II,
  input  logic [12:0]                in_op,
  input  logic [REG_W-1:0]           in_reg,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       wb_busy,
  output logic [3:0]                 out_en,
  output logic [II_W-1:0]            out_II,
  output logic [12:0]                out_op,
  output logic [REG_W-1:0]           out_reg,
  output logic [DATA_W-1:0]          out_data,
  output logic [3:0]                 out_alten,
  output logic [3:0]                 pause,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int ENT_W = 4 + II_W + 13 + REG_W + DATA_W;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [3:0]        out_en_q, out_en_d;
  logic [II_W-1:0]   out_ii_q, out_ii_d;
  logic [12:0]       out_op_q, out_op_d;
  logic [REG_W-1:0]  out_reg_q, out_reg_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [3:0]        pause_q, pause_d;
  logic              ovf_q, ovf_d;

  logic              full, empty, push_req, push, pop;
  logic [3:0]        rd_en;
  logic [II_W-1:0]   rd_ii;
  logic [12:0]       rd_op;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_data;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_req = (|in_en) & ~except;
  assign pop      = ~empty & ~wb_busy & ~except;
  // At full, a simultaneous pop frees the slot the push lands in; the read sees the old entry.
  assign push     = push_req & (~full | pop);

  assign {rd_en, rd_ii, rd_op, rd_reg, rd_data} = mem_q[rd_ptr_q];

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_en_d   = 4'h0;
    out_ii_d   = out_ii_q;
    out_op_d   = out_op_q;
    out_reg_d  = out_reg_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q | (push_req & full & ~pop);

    if (push) begin
      mem_d[wr_ptr_q] = {in_en, in_II, in_op, in_reg, in_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      out_en_d   = rd_en;
      out_ii_d   = rd_ii;
      out_op_d   = rd_op;
      out_reg_d  = rd_reg;
      out_data_d = rd_data;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (except) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Stall one entry early so a result already in flight still has a slot.
    pause_d = (count_d >= CW'(DEPTH - 1)) ? 4'hF : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_en_q   <= '0;
      out_ii_q   <= '0;
      out_op_q   <= '0;
      out_reg_q  <= '0;
      out_data_q <= '0;
      pause_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_en_q   <= out_en_d;
      out_ii_q   <= out_ii_d;
      out_op_q   <= out_op_d;
      out_reg_q  <= out_reg_d;
      out_data_q <= out_data_d;
      pause_q    <= pause_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_en       = out_en_q;
  assign out_alten    = out_en_q;
  assign out_II       = out_ii_q;
  assign out_op       = out_op_q;
  assign out_reg      = out_reg_q;
  assign out_data     = out_data_q;
  assign pause        = pause_q;
  assign count        = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fpusqr_alt_wb_queue.sv
// Directed bench for fpusqr_alt_wb_queue: vector table for push/drain/overflow/full
// sequences, plus hand-written flush and reset-mid-drain sequences.
module tb_fpusqr_alt_wb_queue;

  logic        clk = 1'b0;
  logic        rst, except, wb_busy;
  logic [3:0]  in_en;
  logic [9:0]  in_II;
  logic [12:0] in_op;
  logic [8:0]  in_reg;
  logic [83:0] in_data;
  logic [3:0]  out_en, out_alten, pause;
  logic [9:0]  out_II;
  logic [12:0] out_op;
  logic [8:0]  out_reg;
  logic [83:0] out_data;
  logic [2:0]  count;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpusqr_alt_wb_queue dut (
    .clk(clk), .rst(rst), .except(except), .in_en(in_en), .in_II(in_II),
    .in_op(in_op), .in_reg(in_reg), .in_data(in_data), .wb_busy(wb_busy),
    .out_en(out_en), .out_II(out_II), .out_op(out_op), .out_reg(out_reg),
    .out_data(out_data), .out_alten(out_alten), .pause(pause), .count(count),
    .overflow_err(overflow_err)
  );

  typedef struct {
    logic       rst;
    logic       exc;
    logic [3:0] en;
    logic [9:0] ii;
    logic       busy;
    logic [3:0] x_en;
    logic [9:0] x_ii;
    logic [2:0] x_cnt;
    logic [3:0] x_pause;
    logic       x_ovf;
  } vec_t;

  vec_t vecs[$];

  // Side fields are derived from the instruction index so drained payloads can be checked.
  function automatic logic [12:0] op_of(input logic [9:0] ii);
    return 13'h100 + {3'b0, ii};
  endfunction
  function automatic logic [8:0] reg_of(input logic [9:0] ii);
    return ii[8:0] + 9'h0C;
  endfunction
  function automatic logic [83:0] data_of(input logic [9:0] ii);
    return {ii[3:0], {8{ii}}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] en,
                       input logic [9:0] ii, input logic busy);
    rst     = r;
    except  = e;
    in_en   = en;
    in_II   = ii;
    in_op   = op_of(ii);
    in_reg  = reg_of(ii);
    in_data = data_of(ii);
    wb_busy = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] x_en, input logic [9:0] x_ii,
                           input logic [2:0] x_cnt, input logic [3:0] x_pause, input logic x_ovf);
    chk({tag, ".out_en"}, 128'(out_en), 128'(x_en));
    chk({tag, ".out_alten"}, 128'(out_alten), 128'(x_en));
    chk({tag, ".out_II"}, 128'(out_II), 128'(x_ii));
    chk({tag, ".count"}, 128'(count), 128'(x_cnt));
    chk({tag, ".pause"}, 128'(pause), 128'(x_pause));
    chk({tag, ".overflow_err"}, 128'(overflow_err), 128'(x_ovf));
    if (x_en != 4'h0) begin
      chk({tag, ".out_op"}, 128'(out_op), 128'(op_of(x_ii)));
      chk({tag, ".out_reg"}, 128'(out_reg), 128'(reg_of(x_ii)));
      chk({tag, ".out_data"}, 128'(out_data), 128'(data_of(x_ii)));
    end
  endtask

  function automatic vec_t v(input logic r, input logic e, input logic [3:0] en,
                             input logic [9:0] ii, input logic busy, input logic [3:0] x_en,
                             input logic [9:0] x_ii, input logic [2:0] x_cnt,
                             input logic [3:0] x_pause, input logic x_ovf);
    vec_t t;
    t.rst = r; t.exc = e; t.en = en; t.ii = ii; t.busy = busy;
    t.x_en = x_en; t.x_ii = x_ii; t.x_cnt = x_cnt; t.x_pause = x_pause; t.x_ovf = x_ovf;
    return t;
  endfunction

  initial begin
    //            rst exc en    ii      busy  x_en  x_ii    cnt pause  ovf
    vecs.push_back(v(1, 0, 4'h0, 10'h00, 0,   4'h0, 10'h00, 0, 4'h0, 0));  // reset
    // single push, out exactly two cycles after in_en
    vecs.push_back(v(0, 0, 4'h1, 10'h05, 0,   4'h0, 10'h00, 1, 4'h0, 0));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h1, 10'h05, 0, 4'h0, 0));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h0, 10'h05, 0, 4'h0, 0));
    // backpressure, pause at count 3
    vecs.push_back(v(0, 0, 4'h3, 10'h01, 1,   4'h0, 10'h05, 1, 4'h0, 0));
    vecs.push_back(v(0, 0, 4'h5, 10'h02, 1,   4'h0, 10'h05, 2, 4'h0, 0));
    vecs.push_back(v(0, 0, 4'hF, 10'h03, 1,   4'h0, 10'h05, 3, 4'hF, 0));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h3, 10'h01, 2, 4'h0, 0));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h5, 10'h02, 1, 4'h0, 0));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'hF, 10'h03, 0, 4'h0, 0));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 1,   4'h0, 10'h03, 0, 4'h0, 0));  // empty + busy
    // overflow: fifth push dropped
    vecs.push_back(v(0, 0, 4'h1, 10'h11, 1,   4'h0, 10'h03, 1, 4'h0, 0));
    vecs.push_back(v(0, 0, 4'h1, 10'h12, 1,   4'h0, 10'h03, 2, 4'h0, 0));
    vecs.push_back(v(0, 0, 4'h1, 10'h13, 1,   4'h0, 10'h03, 3, 4'hF, 0));
    vecs.push_back(v(0, 0, 4'h1, 10'h14, 1,   4'h0, 10'h03, 4, 4'hF, 0));
    vecs.push_back(v(0, 0, 4'h1, 10'h15, 1,   4'h0, 10'h03, 4, 4'hF, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h1, 10'h11, 3, 4'hF, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h1, 10'h12, 2, 4'h0, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h1, 10'h13, 1, 4'h0, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h1, 10'h14, 0, 4'h0, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h0, 10'h14, 0, 4'h0, 1));
    // push+pop at full
    vecs.push_back(v(0, 0, 4'h2, 10'h21, 1,   4'h0, 10'h14, 1, 4'h0, 1));
    vecs.push_back(v(0, 0, 4'h2, 10'h22, 1,   4'h0, 10'h14, 2, 4'h0, 1));
    vecs.push_back(v(0, 0, 4'h2, 10'h23, 1,   4'h0, 10'h14, 3, 4'hF, 1));
    vecs.push_back(v(0, 0, 4'h2, 10'h24, 1,   4'h0, 10'h14, 4, 4'hF, 1));
    vecs.push_back(v(0, 0, 4'h8, 10'h09, 0,   4'h2, 10'h21, 4, 4'hF, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h2, 10'h22, 3, 4'hF, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h2, 10'h23, 2, 4'h0, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h2, 10'h24, 1, 4'h0, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h8, 10'h09, 0, 4'h0, 1));
    vecs.push_back(v(0, 0, 4'h0, 10'h00, 0,   4'h0, 10'h09, 0, 4'h0, 1));

    drive(1, 0, 4'h0, 10'h00, 0);
    tick();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].exc, vecs[i].en, vecs[i].ii, vecs[i].busy);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_ii, vecs[i].x_cnt,
                vecs[i].x_pause, vecs[i].x_ovf);
    end

    // flush with three queued entries and a colliding push
    drive(0, 0, 4'h1, 10'h31, 1); tick();
    drive(0, 0, 4'h1, 10'h32, 1); tick();
    drive(0, 0, 4'h1, 10'h33, 1); tick();
    check_out("flush.pre", 4'h0, 10'h09, 3'd3, 4'hF, 1'b1);
    drive(0, 1, 4'h1, 10'h34, 0); tick();
    check_out("flush.now", 4'h0, 10'h09, 3'd0, 4'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 4'h0, 10'h00, 0); tick();
      check_out($sformatf("flush.idle%0d", k), 4'h0, 10'h09, 3'd0, 4'h0, 1'b1);
    end
    // pointers must restart together after a flush
    drive(0, 0, 4'h4, 10'h35, 0); tick();
    check_out("flush.repush", 4'h0, 10'h09, 3'd1, 4'h0, 1'b1);
    drive(0, 0, 4'h0, 10'h00, 0); tick();
    check_out("flush.redrain", 4'h4, 10'h35, 3'd0, 4'h0, 1'b1);

    // reset while draining
    drive(0, 0, 4'h1, 10'h41, 1); tick();
    drive(0, 0, 4'h1, 10'h42, 1); tick();
    drive(0, 0, 4'h0, 10'h00, 0); tick();
    check_out("rst.pre", 4'h1, 10'h41, 3'd1, 4'h0, 1'b1);
    drive(1, 0, 4'h0, 10'h00, 0); tick();
    check_out("rst.now", 4'h0, 10'h00, 3'd0, 4'h0, 1'b0);
    drive(0, 0, 4'h0, 10'h00, 0); tick();
    check_out("rst.after", 4'h0, 10'h00, 3'd0, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
